sequence_checker: RTL and testbench

//  Receive-side checker for the sequence generator's 8-bit data stream.

---
 rtl/sequence_checker.sv | 129 ++++++++++++
 tb/tb_sequence_checker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// Receive-side checker for an arithmetic data stream: hunts for the sequence,
// verifies it over several samples, then counts matches/mismatches while locked.
module sequence_checker #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 1,
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     data,
  output logic                 locked,
  output logic                 error,
  output logic [WIDTH-1:0]     expected,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  // state  | meaning
  // HUNT   | no reference yet; next sample seeds the prediction
  // VERIFY | counting consecutive in-sequence samples toward lock
  // LOCKED | synchronised; matches/mismatches are counted
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [WIDTH-1:0]     STEP_V  = WIDTH'(STEP);
  localparam logic [RUN_W-1:0]     LOCK_V  = RUN_W'(LOCK_THRESH);
  localparam logic [MISS_W-1:0]    LOSS_V  = MISS_W'(LOSS_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic [WIDTH-1:0]      r_expected;
  logic [RUN_W-1:0]      r_run;
  logic [MISS_W-1:0]     r_miss;
  logic [CNT_WIDTH-1:0]  r_match_cnt;
  logic [CNT_WIDTH-1:0]  r_error_cnt;
  logic                  r_error;

  state_t                w_state_nxt;
  logic [WIDTH-1:0]      w_expected_nxt;
  logic [RUN_W-1:0]      w_run_nxt;
  logic [MISS_W-1:0]     w_miss_nxt;
  logic [CNT_WIDTH-1:0]  w_match_cnt_nxt;
  logic [CNT_WIDTH-1:0]  w_error_cnt_nxt;
  logic                  w_error_nxt;
  logic                  w_hit;
  logic [RUN_W-1:0]      w_run_inc;
  logic [MISS_W-1:0]     w_miss_inc;

  assign w_hit      = (data == r_expected);
  assign w_run_inc  = r_run + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_expected_nxt  = r_expected;
    w_run_nxt       = r_run;
    w_miss_nxt      = r_miss;
    w_match_cnt_nxt = r_match_cnt;
    w_error_cnt_nxt = r_error_cnt;
    w_error_nxt     = 1'b0;
    if (enable) begin
      case (r_state)
        HUNT: begin
          w_expected_nxt = data + STEP_V;
          w_run_nxt      = RUN_W'(1);
          w_state_nxt    = VERIFY;
        end
        VERIFY: begin
          if (w_hit) begin
            w_run_nxt      = w_run_inc;
            w_expected_nxt = r_expected + STEP_V;
            if (w_run_inc == LOCK_V) w_state_nxt = LOCKED;
          end else begin
            w_expected_nxt = data + STEP_V;
            w_run_nxt      = RUN_W'(1);
          end
        end
        LOCKED: begin
          // prediction free-runs while locked so a single glitch does not reseed
          w_expected_nxt = r_expected + STEP_V;
          if (w_hit) begin
            w_miss_nxt = '0;
            if (r_match_cnt != CNT_MAX) w_match_cnt_nxt = r_match_cnt + 1'b1;
          end else begin
            w_error_nxt = 1'b1;
            if (r_error_cnt != CNT_MAX) w_error_cnt_nxt = r_error_cnt + 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == LOSS_V) begin
              w_state_nxt = HUNT;
              w_miss_nxt  = '0;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_expected  <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_match_cnt <= '0;
      r_error_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_run       <= w_run_nxt;
      r_miss      <= w_miss_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_error_cnt <= w_error_cnt_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign locked      = (r_state == LOCKED);
  assign error       = r_error;
  assign expected    = r_expected;
  assign match_count = r_match_cnt;
  assign error_count = r_error_cnt;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus randomized traffic,
// all checked against a lock/count model of the stream rules.
module tb_sequence_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  data;
  logic        locked;
  logic        error;
  logic [7:0]  expected;
  logic [15:0] match_count;
  logic [15:0] error_count;

  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 = hunting, 1 = verifying, 2 = locked
  int m_phase = 0;
  int m_exp   = 0;
  int m_run   = 0;
  int m_miss  = 0;
  int m_mc    = 0;
  int m_ec    = 0;
  int m_err   = 0;

  sequence_checker dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .data        (data),
    .locked      (locked),
    .error       (error),
    .expected    (expected),
    .match_count (match_count),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input int rst_n, input int en, input int d);
    if (rst_n == 0) begin
      m_phase = 0; m_exp = 0; m_run = 0; m_miss = 0; m_mc = 0; m_ec = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (en == 0) return;
    if (m_phase == 0) begin
      m_exp = (d + 1) % 256; m_run = 1; m_phase = 1;
    end else if (m_phase == 1) begin
      if (d == m_exp) begin
        m_run++;
        m_exp = (m_exp + 1) % 256;
        if (m_run >= 4) m_phase = 2;
      end else begin
        m_exp = (d + 1) % 256; m_run = 1;
      end
    end else begin
      if (d == m_exp) begin
        if (m_mc < 65535) m_mc++;
        m_miss = 0;
      end else begin
        m_err = 1;
        if (m_ec < 65535) m_ec++;
        m_miss++;
        if (m_miss >= 2) begin m_phase = 0; m_miss = 0; end
      end
      m_exp = (m_exp + 1) % 256;
    end
  endfunction

  task automatic cycle(input logic rst_n, input logic en, input logic [7:0] d);
    reset = rst_n; enable = en; data = d;
    @(posedge clk);
    model_edge(int'(rst_n), int'(en), int'(d));
    #1;
    chk("locked",      {31'b0, locked},       (m_phase == 2) ? 1 : 0);
    chk("error",       {31'b0, error},        m_err);
    chk("expected",    {24'b0, expected},     m_exp);
    chk("match_count", {16'b0, match_count},  m_mc);
    chk("error_count", {16'b0, error_count},  m_ec);
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, 1'b1, d);
  endtask

  initial begin
    logic [7:0] hold_exp;
    int v;
    reset = 1'b0; enable = 1'b0; data = 8'h00;
    #2;

    // 1: reset with enable high and random data
    repeat (2) cycle(1'b0, 1'b1, 8'($urandom));
    chk("rst_expected", {24'b0, expected}, 32'h0);
    chk("rst_locked", {31'b0, locked}, 32'h0);

    // 2: lock on 0x10..0x13
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h10 + i));
      chk("lock_no_err", {31'b0, error}, 32'h0);
    end
    chk("lock_locked", {31'b0, locked}, 32'h1);
    chk("lock_expected", {24'b0, expected}, 32'h14);
    chk("lock_mc", {16'b0, match_count}, 32'h0);

    // 3: drop lock, relock on FE..01 across the wrap, then 0x02 matches
    send(8'hF0); send(8'hF0);
    chk("drop_locked", {31'b0, locked}, 32'h0);
    send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    chk("wrap_locked", {31'b0, locked}, 32'h1);
    send(8'h02);
    chk("wrap_mc", {16'b0, match_count}, 32'h1);
    chk("wrap_expected", {24'b0, expected}, 32'h03);

    // 4: single error while locked
    for (int i = 3; i < 8'h20; i++) send(8'(i));
    chk("pre4_expected", {24'b0, expected}, 32'h20);
    send(8'h55);
    chk("single_err", {31'b0, error}, 32'h1);
    chk("single_locked", {31'b0, locked}, 32'h1);
    send(8'h21);
    chk("single_err_clr", {31'b0, error}, 32'h0);
    chk("single_mc", {16'b0, match_count}, 32'd31);
    chk("single_ec", {16'b0, error_count}, 32'd3);

    // 5: two consecutive mismatches drop lock, then relock at 0x80
    send(8'h00);
    chk("dbl_err1", {31'b0, error}, 32'h1);
    send(8'h00);
    chk("dbl_err2", {31'b0, error}, 32'h1);
    chk("dbl_locked", {31'b0, locked}, 32'h0);
    chk("dbl_ec", {16'b0, error_count}, 32'd5);
    for (int i = 0; i < 4; i++) send(8'(8'h80 + i));
    chk("relock", {31'b0, locked}, 32'h1);
    chk("relock_expected", {24'b0, expected}, 32'h84);

    // 6: enable gaps hold state, then mid-stream reset
    send(8'h84);
    hold_exp = expected;
    repeat (3) cycle(1'b1, 1'b0, 8'($urandom));
    chk("gap_expected", {24'b0, expected}, 32'h85);
    send(8'h85);
    cycle(1'b0, 1'b1, 8'h86);
    chk("mid_rst_locked", {31'b0, locked}, 32'h0);
    chk("mid_rst_mc", {16'b0, match_count}, 32'h0);
    chk("mid_rst_ec", {16'b0, error_count}, 32'h0);
    if (hold_exp != 8'h85) chk("gap_hold_seed", {24'b0, hold_exp}, 32'h85);

    // randomized traffic: mostly in-sequence words, gaps, occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic rn, en;
      logic [7:0] d;
      v  = int'($urandom_range(0, 99));
      rn = (v < 2) ? 1'b0 : 1'b1;
      en = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      d  = ($urandom_range(0, 9) < 8) ? 8'(m_exp) : 8'($urandom);
      cycle(rn, en, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
